svnet_pipeline_credit_manager: RTL and testbench

- Multi-channel successor to the single-channel pipeline used-space tracker.
- Sits between a set of buffered sources (FIFOs) and a fixed-latency processing pipeline.
- Per channel, tracks reads that have been issued into the pipeline but not yet retired, so downstream logic sees used space net of in-flight data.
- Adds multi-beat reads per cycle, sticky error detection with clamping, and a drain/flush handshake for safe reconfiguration between layers.

---
 rtl/svnet_pipeline_credit_manager.sv | 190 +++++++++++++++++++
 tb/tb_svnet_pipeline_credit_manager.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/svnet_pipeline_credit_manager.sv
// ---------------------------------------------------------------------------
// svnet_pipeline_credit_manager
//
// Purpose:
//   Per-channel tracker of reads issued into a fixed-latency pipeline that
//   have not yet retired. Reports each source's used space net of in-flight
//   data, keeps sticky error flags with clamped counters, and provides a
//   drain/flush handshake for safe reconfiguration.
//
// Optional feature (macro SVNET_PIPELINE_CREDIT_STATS_EN):
//   Adds output peak_inflight (per-channel high-water mark of the in-flight
//   counter, cleared by reset or err_clear) plus simulation assertions on
//   the three error conditions.
//
// Ports:
//   clk                  clock
//   rst_n                asynchronous active-low reset
//   source_used_space    CHANNELS*CW  per-channel source occupancy
//   source_read_count    CHANNELS*RW  reads issued this cycle
//   pipeline_used_space  CHANNELS*CW  occupancy net of in-flight reads
//   pipeline_read_count  CHANNELS*RW  reads retired this cycle
//   flush_req            pulse, request drain of all channels
//   source_read_en       upstream may issue reads (low while draining)
//   flush_done           pulse, all channels drained
//   idle                 registered: all in-flight counters were zero
//   err_clear            clears sticky error flags
//   error[2:0]           sticky: [0] overread, [1] underflow, [2] overflow
//   peak_inflight        CHANNELS*IW  (stats build only)
// ---------------------------------------------------------------------------
module svnet_pipeline_credit_manager #(
  parameter  int CHANNELS  = 4,
  parameter  int DEPTH     = 16,
  parameter  int DELAY     = 4,
  parameter  int MAX_READS = 1,
  localparam int CW        = $clog2(DEPTH) + 1,
  localparam int RW        = $clog2(MAX_READS) + 1,
  localparam int CAP       = DELAY * MAX_READS,
  localparam int IW        = $clog2(CAP) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CHANNELS*CW-1:0] source_used_space,
  input  logic [CHANNELS*RW-1:0] source_read_count,
  output logic [CHANNELS*CW-1:0] pipeline_used_space,
  input  logic [CHANNELS*RW-1:0] pipeline_read_count,
  input  logic                   flush_req,
  output logic                   source_read_en,
  output logic                   flush_done,
  output logic                   idle,
  input  logic                   err_clear,
  output logic [2:0]             error
`ifdef SVNET_PIPELINE_CREDIT_STATS_EN
  ,
  output logic [CHANNELS*IW-1:0] peak_inflight
`endif
);

  // Wide enough to compare occupancy against in-flight count without loss.
  localparam int XW = CW + IW;
  // Signed width for inflight + reads - retires.
  localparam int SW = IW + RW + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t              r_state;
  logic                r_read_en;
  logic                r_flush_done;
  logic                r_idle;
  logic [2:0]          r_error;

  logic [CHANNELS-1:0] w_overread;
  logic [CHANNELS-1:0] w_underflow;
  logic [CHANNELS-1:0] w_overflow;
  logic [CHANNELS-1:0] w_next_zero;
  logic [CHANNELS-1:0] w_cur_zero;
  logic [CHANNELS-1:0] w_read_any;
  logic [2:0]          w_new_err;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [CW-1:0]        w_src_used;
    logic [RW-1:0]        w_rd;
    logic [RW-1:0]        w_rt;
    logic                 w_clamp;
    logic [CW-1:0]        w_pus;
    logic signed [SW-1:0] w_sum;
    logic [IW-1:0]        w_inflight_d;
    logic [IW-1:0]        r_inflight;

    assign w_src_used = source_used_space[gi*CW +: CW];
    assign w_rd       = source_read_count[gi*RW +: RW];
    assign w_rt       = pipeline_read_count[gi*RW +: RW];

    // When more is in flight than the source holds, report empty rather
    // than wrapping. If not clamped, r_inflight fits in CW bits.
    assign w_clamp = XW'(r_inflight) > XW'(w_src_used);
    assign w_pus   = w_clamp ? '0 : (w_src_used - CW'(r_inflight));
    assign pipeline_used_space[gi*CW +: CW] = w_pus;

    assign w_overread[gi] = w_clamp | (XW'(w_rd) > XW'(w_pus));

    assign w_sum = $signed(SW'(r_inflight)) + $signed(SW'(w_rd))
                 - $signed(SW'(w_rt));
    assign w_underflow[gi] = (w_sum < 0);
    assign w_overflow[gi]  = (w_sum > $signed(SW'(CAP)));

    assign w_inflight_d = w_underflow[gi] ? '0 :
                          w_overflow[gi]  ? IW'(CAP) : w_sum[IW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_inflight <= '0;
      else        r_inflight <= w_inflight_d;
    end

    assign w_next_zero[gi] = (w_inflight_d == '0);
    assign w_cur_zero[gi]  = (r_inflight == '0);
    assign w_read_any[gi]  = |w_rd;

`ifdef SVNET_PIPELINE_CREDIT_STATS_EN
    logic [IW-1:0] r_peak;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_peak <= '0;
      else if (err_clear)              r_peak <= '0;
      else if (w_inflight_d > r_peak)  r_peak <= w_inflight_d;
    end

    assign peak_inflight[gi*IW +: IW] = r_peak;

    a_no_overread:  assert property (@(posedge clk) disable iff (!rst_n) !w_overread[gi]);
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !w_underflow[gi]);
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !w_overflow[gi]);
`endif
  end

  // Reads while draining are still counted but flagged as overreads.
  assign w_new_err[0] = (|w_overread) | ((r_state == DRAIN) & (|w_read_any));
  assign w_new_err[1] = |w_underflow;
  assign w_new_err[2] = |w_overflow;

  // A new error in the same cycle as err_clear keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= '0;
      r_idle  <= 1'b1;
    end else begin
      r_error <= (r_error & ~{3{err_clear}}) | w_new_err;
      r_idle  <= &w_cur_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_read_en    <= 1'b1;
      r_flush_done <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (flush_req) begin
            r_state   <= DRAIN;
            r_read_en <= 1'b0;
          end
        end
        DRAIN: begin
          // Looks at next-state counters so an idle drain takes one cycle.
          if (&w_next_zero) begin
            r_state      <= DONE;
            r_flush_done <= 1'b1;
          end
        end
        DONE: begin
          r_state      <= RUN;
          r_flush_done <= 1'b0;
          r_read_en    <= 1'b1;
        end
        default: begin
          r_state      <= RUN;
          r_flush_done <= 1'b0;
          r_read_en    <= 1'b1;
        end
      endcase
    end
  end

  assign source_read_en = r_read_en;
  assign flush_done     = r_flush_done;
  assign idle           = r_idle;
  assign error          = r_error;

endmodule

// File: tb/tb_svnet_pipeline_credit_manager.sv
module tb_svnet_pipeline_credit_manager;

  localparam int CH  = 4;
  localparam int CW  = 5;
  localparam int RW  = 1;
  localparam int CAP = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [CH*CW-1:0]  source_used_space;
  logic [CH*RW-1:0]  source_read_count;
  logic [CH*CW-1:0]  pipeline_used_space;
  logic [CH*RW-1:0]  pipeline_read_count;
  logic              flush_req;
  logic              source_read_en;
  logic              flush_done;
  logic              idle;
  logic              err_clear;
  logic [2:0]        error;

  svnet_pipeline_credit_manager dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .source_used_space   (source_used_space),
    .source_read_count   (source_read_count),
    .pipeline_used_space (pipeline_used_space),
    .pipeline_read_count (pipeline_read_count),
    .flush_req           (flush_req),
    .source_read_en      (source_read_en),
    .flush_done          (flush_done),
    .idle                (idle),
    .err_clear           (err_clear),
    .error               (error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Stimulus for the current cycle.
  int used_v [CH];
  int rd_v   [CH];
  int rt_v   [CH];
  bit flush_v;
  bit clr_v;

  // Reference model: in-flight counts, sticky errors, handshake phase
  // (0 = running, 1 = draining, 2 = done pulse), registered idle.
  int         m_infl [CH];
  logic [2:0] m_err;
  int         m_phase;
  logic       m_idle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_pus(int c);
    return (m_infl[c] > used_v[c]) ? 0 : used_v[c] - m_infl[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) m_infl[c] = 0;
    m_err   = 3'b000;
    m_phase = 0;
    m_idle  = 1'b1;
  endtask

  task automatic clear_stim();
    for (int c = 0; c < CH; c++) begin
      rd_v[c] = 0;
      rt_v[c] = 0;
    end
    flush_v = 1'b0;
    clr_v   = 1'b0;
  endtask

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      source_used_space[c*CW +: CW]   = CW'(used_v[c]);
      source_read_count[c*RW +: RW]   = RW'(rd_v[c]);
      pipeline_read_count[c*RW +: RW] = RW'(rt_v[c]);
    end
    flush_req = flush_v;
    err_clear = clr_v;
  endtask

  task automatic check_outputs(input string tag);
    for (int c = 0; c < CH; c++)
      check($sformatf("%s pus%0d", tag, c), 32'(pipeline_used_space[c*CW +: CW]), 32'(m_pus(c)));
    check($sformatf("%s read_en", tag), 32'(source_read_en), 32'(m_phase == 0));
    check($sformatf("%s flush_done", tag), 32'(flush_done), 32'(m_phase == 2));
    check($sformatf("%s idle", tag), 32'(idle), 32'(m_idle));
    check($sformatf("%s error", tag), 32'(error), 32'(m_err));
  endtask

  // Advance the model across one active clock edge.
  task automatic model_step();
    int         nxt [CH];
    logic [2:0] new_err;
    bit         cur_zero;
    bit         next_zero;
    new_err   = 3'b000;
    cur_zero  = 1'b1;
    next_zero = 1'b1;
    for (int c = 0; c < CH; c++) begin
      int s;
      if (m_infl[c] > used_v[c] || rd_v[c] > m_pus(c)) new_err[0] = 1'b1;
      if (m_phase == 1 && rd_v[c] != 0) new_err[0] = 1'b1;
      s = m_infl[c] + rd_v[c] - rt_v[c];
      if (s < 0) begin
        new_err[1] = 1'b1;
        s = 0;
      end else if (s > CAP) begin
        new_err[2] = 1'b1;
        s = CAP;
      end
      if (m_infl[c] != 0) cur_zero = 1'b0;
      if (s != 0) next_zero = 1'b0;
      nxt[c] = s;
    end
    m_err  = (clr_v ? 3'b000 : m_err) | new_err;
    m_idle = cur_zero;
    case (m_phase)
      0:       if (flush_v) m_phase = 1;
      1:       if (next_zero) m_phase = 2;
      default: m_phase = 0;
    endcase
    for (int c = 0; c < CH; c++) m_infl[c] = nxt[c];
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input string tag);
    drive();
    #1;
    check_outputs(tag);
    model_step();
    $display("cycle %s: used=%0d/%0d/%0d/%0d rd=%b rt=%b flush=%0b clr=%0b -> pus=%h err=%b",
             tag, used_v[0], used_v[1], used_v[2], used_v[3], source_read_count,
             pipeline_read_count, flush_v, clr_v, pipeline_used_space, error);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < CH; c++) used_v[c] = 0;
    clear_stim();
    drive();
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: read every cycle, retire from the fifth cycle on.
    used_v[0] = 10;
    for (int i = 0; i < 8; i++) begin
      rd_v[0] = 1;
      rt_v[0] = (i >= 4) ? 1 : 0;
      cycle("stream");
    end
    clear_stim();
    for (int i = 0; i < 5; i++) begin
      rt_v[0] = (m_infl[0] > 0) ? 1 : 0;
      cycle("stream_drain");
    end

    // Underflow, clear, and clear colliding with a new error.
    clear_stim();
    rt_v[1] = 1;  cycle("underflow");
    rt_v[1] = 0;  cycle("uf_sticky");
    clr_v = 1'b1; cycle("uf_clear");
    rt_v[1] = 1;  cycle("clear_vs_new");
    clear_stim(); cycle("uf_sticky2");
    clr_v = 1'b1; cycle("uf_clear2");
    clr_v = 1'b0; cycle("cleared");

    // In-flight exceeds occupancy: output clamps to zero.
    used_v[0] = 16; used_v[1] = 7; used_v[2] = 9;
    for (int i = 0; i < 3; i++) begin
      rd_v[0] = 1;
      cycle("load3");
    end
    clear_stim();
    used_v[0] = 2; cycle("clamp");
    cycle("clamp_hold");
    for (int i = 0; i < 3; i++) begin
      rt_v[0] = 1;
      cycle("clamp_retire");
    end
    clear_stim();
    clr_v = 1'b1; cycle("clamp_clear");
    clr_v = 1'b0; cycle("clamp_quiet");

    // Flush with in-flight {2,0,1,0} retired over two cycles.
    for (int c = 0; c < CH; c++) used_v[c] = 16;
    rd_v[0] = 1; rd_v[2] = 1; cycle("fl_load_a");
    rd_v[2] = 0;              cycle("fl_load_b");
    clear_stim();
    flush_v = 1'b1;           cycle("fl_req");
    flush_v = 1'b0;
    rt_v[0] = 1; rt_v[2] = 1; cycle("fl_retire_a");
    flush_v = 1'b1;  // ignored while draining
    rt_v[2] = 0;              cycle("fl_retire_b");
    clear_stim();
    for (int i = 0; i < 4; i++) cycle("fl_after");

    // Flush while already idle.
    flush_v = 1'b1; cycle("idle_flush");
    flush_v = 1'b0;
    for (int i = 0; i < 4; i++) cycle("idle_flush_after");

    // Reset asserted in the middle of a drain.
    rd_v[0] = 1; cycle("rst_load_a");
    cycle("rst_load_b");
    clear_stim();
    flush_v = 1'b1; cycle("rst_flush");
    flush_v = 1'b0; cycle("rst_drain");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    check_outputs("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst");

    // Randomized traffic with occasional rule violations.
    for (int i = 0; i < 600; i++) begin
      clear_stim();
      for (int c = 0; c < CH; c++) begin
        if ($urandom % 10 == 0) used_v[c] = $urandom_range(0, 16);
        if (m_phase == 0 && m_pus(c) > 0) rd_v[c] = $urandom % 2;
        if ($urandom % 40 == 0) rd_v[c] = 1;
        if (m_infl[c] > 0) rt_v[c] = ($urandom % 3 != 0) ? 1 : 0;
        if ($urandom % 50 == 0) rt_v[c] = 1;
      end
      flush_v = ($urandom % 30 == 0);
      clr_v   = ($urandom % 20 == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
